// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
//
// Contents:
//   XLEN_DEFAULT, NREGS_DEFAULT : default data width and register count
//   ADDR_MAX_W                  : widest address the zero_reg helper accepts
//   reg_addr_t                  : register address type for the default depth
//   zero_reg(addr)              : true when addr selects the hard-wired zero register
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned ADDR_MAX_W    = 16;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

  // Callers zero-extend narrower addresses to ADDR_MAX_W so one helper serves any depth.
  function automatic logic zero_reg(input logic [ADDR_MAX_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for the register file.
//
// A reserve marks a register as awaiting a writeback; any enabled write to that
// register clears it. A reserve and a write to the same register in the same
// cycle leave it busy, since the reserve belongs to a newer producer.
// Register 0 is never busy.
//
// Ports:
//   clk_i       core clock, rising edge
//   reset_ni    asynchronous active-low reset, clears every busy bit
//   wr_en_i     write enables, one per write port
//   wr_addr_i   write addresses, port j at [j*AW +: AW]
//   rsv_en_i    reserve request
//   rsv_addr_i  register to reserve
//   busy_o      full busy vector, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [NUM_WR-1:0]                  wr_en_i,
  input  logic [NUM_WR*$clog2(NREGS)-1:0]    wr_addr_i,
  input  logic                               rsv_en_i,
  input  logic [$clog2(NREGS)-1:0]           rsv_addr_i,
  output logic [NREGS-1:0]                   busy_o
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0] busy_d, busy_q;
  logic [AW-1:0]    wa;

  always_comb begin
    busy_d = busy_q;
    wa     = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa = wr_addr_i[j*AW +: AW];
      if (wr_en_i[j] && !zero_reg(ADDR_MAX_W'(wa))) begin
        busy_d[wa] = 1'b0;
      end
    end
    // Applied after the clears so a same-cycle reserve wins.
    if (rsv_en_i && !zero_reg(ADDR_MAX_W'(rsv_addr_i))) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hard-wired zero register and busy scoreboard.
//
// Reads are combinational. Writes land on the rising edge; on a same-address
// conflict the highest-indexed write port wins. Writes and reserves of register 0
// are ignored.
//
// Build option: define REGFILE_BYPASS_EN for write-through reads. A read that
// matches an enabled same-cycle write returns that write's data (highest matching
// port wins), and its busy bit reads 1 only if that cycle's reserve targets it.
// Without the macro, reads show the stored values and busy bits only.
//
// Ports:
//   clk_i       core clock, rising edge
//   reset_ni    asynchronous active-low reset, clears registers and busy bits
//   rd_addr_i   read addresses, port k at [k*AW +: AW]
//   rd_data_o   read data, port k at [k*XLEN +: XLEN]
//   rd_busy_o   busy bit of each read address
//   wr_en_i     write enables
//   wr_addr_i   write addresses, port j at [j*AW +: AW]
//   wr_data_i   write data, port j at [j*XLEN +: XLEN]
//   rsv_en_i    reserve request (mark destination pending)
//   rsv_addr_i  register to reserve
//   busy_vec_o  full scoreboard vector, bit 0 always 0
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  // Derived from NREGS; do not override.
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [AW-1:0]            rsv_addr_i,
  output logic [NREGS-1:0]         busy_vec_o
);

  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] regs_q [NREGS];
  logic [AW-1:0]   wa;
  logic [AW-1:0]   ra;
`ifdef REGFILE_BYPASS_EN
  logic [AW-1:0]   ba;
`endif

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .busy_o     (busy_vec_o)
  );

  // Ascending port order makes the highest-indexed writer the last assignment.
  always_comb begin
    regs_d = regs_q;
    wa     = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wa = wr_addr_i[j*AW +: AW];
      if (wr_en_i[j] && !zero_reg(ADDR_MAX_W'(wa))) begin
        regs_d[wa] = wr_data_i[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Register 0 holds 0 and is never busy, so the plain lookup covers it.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    ra        = '0;
`ifdef REGFILE_BYPASS_EN
    ba        = '0;
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr_i[k*AW +: AW];
      rd_data_o[k*XLEN +: XLEN] = regs_q[ra];
      rd_busy_o[k]              = busy_vec_o[ra];
`ifdef REGFILE_BYPASS_EN
      // Gated by reset so reads stay 0 while reset is held with writes pending.
      for (int j = 0; j < NUM_WR; j++) begin
        ba = wr_addr_i[j*AW +: AW];
        if (reset_ni && wr_en_i[j] && !zero_reg(ADDR_MAX_W'(ba)) && (ba == ra)) begin
          rd_data_o[k*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
          rd_busy_o[k]              = rsv_en_i && (rsv_addr_i == ra);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed cases with literal expectations,
// then randomized traffic (including mid-cycle async resets) against an
// array-based reference model, compared on every falling clock edge.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW = 5;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic [NREGS-1:0]       busy_vec;

  int n_chk = 0;
  int n_pass = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];

  regfile_mp_sb dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .busy_vec_o (busy_vec)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  // Expected read result of port k given the model state and current inputs.
  function automatic void model_read(input int k, output logic [XLEN-1:0] d, output logic b);
    int a;
    a = int'(rd_addr[k*AW +: AW]);
    d = m_regs[a];
    b = m_busy[a];
    if (!reset_n) begin
      d = '0;
      b = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0 && int'(wr_addr[j*AW +: AW]) == a) begin
          d = wr_data[j*XLEN +: XLEN];
          b = rsv_en && int'(rsv_addr) == a;
        end
      end
    end
`endif
  endfunction

  always @(negedge reset_n) model_clear();

  always @(posedge clk) begin
    if (reset_n) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          m_regs[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
          m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic [XLEN-1:0]  ed;
    logic             eb;
    logic [NREGS-1:0] ev;
    for (int k = 0; k < NUM_RD; k++) begin
      model_read(k, ed, eb);
      chk($sformatf("cmp rd_data[%0d] addr=%0d", k, rd_addr[k*AW +: AW]),
          64'(rd_data[k*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("cmp rd_busy[%0d] addr=%0d", k, rd_addr[k*AW +: AW]),
          64'(rd_busy[k]), 64'(eb));
    end
    for (int r = 0; r < NREGS; r++) ev[r] = reset_n ? m_busy[r] : 1'b0;
    chk("cmp busy_vec", 64'(busy_vec), 64'(ev));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  initial begin
    model_clear();
    reset_n  = 1'b0;
    rd_addr  = {5'd7, 5'd5};
    wr_en    = 2'b11;
    wr_addr  = {5'd7, 5'd5};
    wr_data  = {32'h2222_2222, 32'h1111_1111};
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    #1;
    chk("reset rd_data", 64'(rd_data), 64'h0);
    chk("reset busy_vec", 64'(busy_vec), 64'h0);
    cyc();
    cyc();
    chk("reset held rd_data", 64'(rd_data), 64'h0);
    chk("reset held busy_vec", 64'(busy_vec), 64'h0);
    idle();
    reset_n = 1'b1;
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("post-reset x5", 64'(rd_data[31:0]), 64'h0);

    // Basic write/read, same-cycle view depends on bypass build.
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'h0, 32'hDEAD_BEEF};
    rd_addr = {5'd0, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x3 same cycle", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
`else
    chk("x3 same cycle", 64'(rd_data[31:0]), 64'h0);
`endif
    cyc();
    idle();
    #1;
    chk("x3 next cycle", 64'(rd_data[31:0]), 64'hDEAD_BEEF);

    wr_en   = 2'b10;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'hFFFF_FFFF, 32'h0};
    rd_addr = {5'd0, 5'd0};
    cyc();
    idle();
    #1;
    chk("x0 stays zero", 64'(rd_data[31:0]), 64'h0);

    // Same-address conflict.
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h2222_2222, 32'h1111_1111};
    cyc();
    idle();
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("x7 conflict", 64'(rd_data[31:0]), 64'h2222_2222);

    // Scoreboard set / clear / reserve-beats-write.
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    cyc();
    idle();
    rd_addr = {5'd9, 5'd0};
    #1;
    chk("x9 busy_vec set", 64'(busy_vec[9]), 64'h1);
    chk("x9 rd_busy set", 64'(rd_busy[1]), 64'h1);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd9};
    wr_data = {32'h0, 32'h0000_0099};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x9 bypass busy", 64'(rd_busy[1]), 64'h0);
`else
    chk("x9 stored busy", 64'(rd_busy[1]), 64'h1);
`endif
    cyc();
    idle();
    #1;
    chk("x9 busy cleared", 64'(busy_vec[9]), 64'h0);
    chk("x9 data", 64'(rd_data[63:32]), 64'h99);
    wr_en    = 2'b10;
    wr_addr  = {5'd9, 5'd0};
    wr_data  = {32'h0000_ABCD, 32'h0};
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    cyc();
    idle();
    #1;
    chk("x9 rsv+wr busy", 64'(busy_vec[9]), 64'h1);
    chk("x9 rsv+wr data", 64'(rd_data[63:32]), 64'hABCD);

    // Bypass case on x4.
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd4};
    wr_data = {32'h0, 32'h0000_0044};
    cyc();
    wr_data = {32'h0, 32'hCAFE_F00D};
    rd_addr = {5'd9, 5'd4};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x4 bypass", 64'(rd_data[31:0]), 64'hCAFE_F00D);
`else
    chk("x4 old value", 64'(rd_data[31:0]), 64'h44);
`endif
    cyc();
    idle();
    #1;
    chk("x4 new value", 64'(rd_data[31:0]), 64'hCAFE_F00D);

    // Async reset between edges while x9 is busy.
    chk("x9 busy before reset", 64'(busy_vec[9]), 64'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async busy_vec", 64'(busy_vec), 64'h0);
    chk("async rd_data", 64'(rd_data), 64'h0);
    cyc();
    reset_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc();
      reset_n  = ($urandom_range(0, 79) != 0);
      wr_en    = NUM_WR'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = pick_addr();
      for (int j = 0; j < NUM_WR; j++) begin
        wr_addr[j*AW +: AW]     = pick_addr();
        wr_data[j*XLEN +: XLEN] = $urandom;
      end
      for (int k = 0; k < NUM_RD; k++) begin
        rd_addr[k*AW +: AW] = ($urandom_range(0, 1) == 0) ? wr_addr[k*AW +: AW] : pick_addr();
      end
    end
    cyc();
    idle();
    reset_n = 1'b1;
    cyc();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the core's decode/writeback stages.
- Generalises the single-write, two-read RF: configurable width, depth, read-port and write-port counts.
- Hard-wired zero register.
- Integrated per-register busy scoreboard so decode can detect pending writebacks, e.g. load-use hazards.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 2, number of write ports; higher index wins on same-address conflict.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk_i  in  1  core clock, rising-edge.
- reset_ni  in  1  asynchronous, active-low reset.
- rd_addr_i  in  NUM_RD*AW  read addresses; port k at [k*AW +: AW].
- rd_data_o  out  NUM_RD*XLEN  read data; port k at [k*XLEN +: XLEN].
- rd_busy_o  out  NUM_RD  scoreboard busy bit of each read address.
- wr_en_i  in  NUM_WR  write enables.
- wr_addr_i  in  NUM_WR*AW  write addresses.
- wr_data_i  in  NUM_WR*XLEN  write data.
- rsv_en_i  in  1  reserve request: mark destination as pending.
- rsv_addr_i  in  AW  register to reserve.
- busy_vec_o  out  NREGS  full scoreboard vector; bit 0 always 0.

Behaviour:
- Reset:
  - reset_ni low asynchronously clears all registers to 0 and all busy bits to 0.
  - rd_data_o then reads 0; rd_busy_o and busy_vec_o read 0.
  - Reset asserted mid-operation discards pending writes and reservations in the same cycle.
- Read path:
  - Purely combinational, zero latency.
  - rd_data_o[k] = regs[rd_addr_i[k]].
  - Reading address 0 always returns 0 and busy 0.
- Write path:
  - On posedge clk_i with reset_ni high, each port j with wr_en_i[j]=1 and wr_addr_i[j]!=0 writes wr_data_i[j].
  - New value is visible on reads the following cycle; bypass is covered under Optional Feature.
  - Writes to address 0 are ignored.
  - Two enabled ports with the same address: highest port index wins, and exactly one value is stored.
- Scoreboard (per register r != 0):
  - Set: rsv_en_i=1 with rsv_addr_i=r sets busy[r] at the next edge.
  - Clear: any enabled write to r clears busy[r] at the next edge.
  - Simultaneous reserve and write to the same r: write data is stored and busy[r] ends at 1 (new producer wins).
  - Reserving an already-busy register leaves it busy; no counting, a single write clears it.
  - Reserve of address 0 is ignored.
- No illegal states; all address values are valid when NREGS = 2**AW.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through):
  - A read whose address matches an enabled same-cycle write (address != 0) returns that write's data combinationally; highest matching port index wins.
  - rd_busy_o for that port reads 0 unless rsv_en_i targets the same address that cycle.
- Undefined:
  - Reads return the stored pre-edge value; the new value appears next cycle.
  - rd_busy_o reflects the stored busy bit only.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEFAULT and NREGS_DEFAULT constants.
  - reg_addr_t typedef (logic [AW-1:0] for the default depth).
  - Helper function zero_reg(addr), returning true when addr == 0.
- One sub-module, regfile_scoreboard: owns the busy vector, set/clear priority and reset. Parameters NREGS and NUM_WR.
- Data array and read/bypass muxing stay in the top module.

Test Plan:
- Reset: drive reset_ni low with writes active.
  - All rd_data_o = 0 and busy_vec_o = 0 while low.
  - After release, read x5 -> 0x00000000.
- Basic write/read: write port0 x3 = 0xDEADBEEF.
  - Next cycle rd_addr[0]=3 -> 0xDEADBEEF.
  - Write x0 = 0xFFFFFFFF -> x0 still reads 0.
- Write conflict: port0 and port1 both write x7, with 0x11111111 and 0x22222222 -> x7 reads 0x22222222.
- Scoreboard:
  - Reserve x9 -> busy_vec_o[9]=1 next cycle; rd_busy_o=1 when reading x9.
  - Write x9 -> busy cleared next cycle.
  - Reserve x9 and write x9 in the same cycle -> busy stays 1, data updated.
- Bypass: write x4 = 0xCAFEF00D while reading x4 in the same cycle.
  - With REGFILE_BYPASS_EN -> 0xCAFEF00D same cycle.
  - Without it -> old value, new value next cycle.
- Async reset mid-operation: assert reset_ni between clock edges while x9 is busy -> busy_vec_o clears immediately, before the next edge.
